// File: rtl/cache_2way_fill_ctrl.sv
// 2-way set-associative write-through cache with no write-allocate and a
// pipelined line-fill FSM, talking to memory through a request/grant port.
module cache_2way_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int SETS   = 64,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              flush,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(WORDS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 1;
    localparam logic [OFF_W:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0] a_tag;
    logic [IDX_W-1:0] a_idx;
    logic [OFF_W-1:0] a_off;
    logic             addr_lsb_unused;

    assign a_tag = addr[ADDR_W-1 -: TAG_W];
    assign a_idx = addr[OFF_W+1 +: IDX_W];
    assign a_off = addr[1 +: OFF_W];
    assign addr_lsb_unused = addr[0];

    logic [1:0][SETS-1:0] valid_q;
    logic [SETS-1:0]      lru_q;
    logic [TAG_W-1:0]     tag_q  [2][SETS];
    logic [DATA_W-1:0]    data_q [2][SETS*WORDS];

    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_idx;
    logic             victim;
    logic [OFF_W:0]   issue_cnt;
    logic [OFF_W:0]   ret_cnt;

    logic hit0, hit1, hit, hit_way, vict;

    assign hit0    = valid_q[0][a_idx] && (tag_q[0][a_idx] == a_tag);
    assign hit1    = valid_q[1][a_idx] && (tag_q[1][a_idx] == a_tag);
    assign hit     = hit0 | hit1;
    assign hit_way = ~hit0;
    assign rdata   = hit ? data_q[hit_way][{a_idx, a_off}] : '0;

    // Fill an empty way first (way0 preferred), otherwise evict the LRU way.
    assign vict = !valid_q[0][a_idx] ? 1'b0 :
                  !valid_q[1][a_idx] ? 1'b1 : lru_q[a_idx];

    logic start_fill, issue_fire, fill_ret, fill_last, rd_upd, wr_upd, do_flush;

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        start_fill = 1'b0;
        issue_fire = 1'b0;
        fill_ret   = 1'b0;
        fill_last  = 1'b0;
        rd_upd     = 1'b0;
        wr_upd     = 1'b0;
        do_flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (we) begin
                        state_d = WRITE;
                    end else if (hit) begin
                        rd_upd = 1'b1;
                    end else begin
                        start_fill = 1'b1;
                        state_d    = FILL;
                    end
                end else if (flush) begin
                    do_flush = 1'b1;
                end
            end
            FILL: begin
                // Issue side and return side advance independently.
                mem_req    = ~issue_cnt[OFF_W];
                mem_addr   = {fill_tag, fill_idx, issue_cnt[OFF_W-1:0], 1'b0};
                issue_fire = mem_req & mem_gnt;
                if (mem_rvalid && !ret_cnt[OFF_W]) begin
                    fill_ret = 1'b1;
                    if (ret_cnt[OFF_W-1:0] == '1) begin
                        fill_last = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr;
                mem_wdata = wdata;
                if (mem_gnt) begin
                    wr_upd  = hit;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall = req && !(state_q == IDLE && !we && hit)
                       && !(state_q == WRITE && mem_gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            lru_q     <= '0;
            fill_tag  <= '0;
            fill_idx  <= '0;
            victim    <= 1'b0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            state_q <= state_d;
            if (start_fill) begin
                fill_tag              <= a_tag;
                fill_idx              <= a_idx;
                victim                <= vict;
                issue_cnt             <= '0;
                ret_cnt               <= '0;
                valid_q[vict][a_idx]  <= 1'b0;
            end
            if (issue_fire) issue_cnt <= issue_cnt + CNT_ONE;
            if (fill_ret)   ret_cnt   <= ret_cnt + CNT_ONE;
            if (fill_last) begin
                valid_q[victim][fill_idx] <= 1'b1;
                lru_q[fill_idx]           <= ~victim;
            end
            if (rd_upd || wr_upd) lru_q[a_idx] <= ~hit_way;
            if (do_flush)         valid_q      <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_ret)  data_q[victim][{fill_idx, ret_cnt[OFF_W-1:0]}] <= mem_rdata;
        if (wr_upd)    data_q[hit_way][{a_idx, a_off}]              <= wdata;
        if (fill_last) tag_q[victim][fill_idx]                      <= fill_tag;
    end

endmodule
